// File: rtl/fixedpoint_div.sv
// Sequential signed Q(WIDTH-FRAC).FRAC divider, restoring shift-subtract, one quotient bit per clock.
// Optional define FXDIV_ROUND_EN: extra guard-bit iteration and round-half-away-from-zero in FIN.
module fixedpoint_div #(
  parameter int unsigned WIDTH = 32,
  parameter int unsigned FRAC  = 21
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [WIDTH-1:0] num,
  input  logic [WIDTH-1:0] den,
  output logic             out_valid,
  input  logic             out_ready,
  output logic [WIDTH-1:0] quot,
  output logic             div_zero,
  output logic             ovf,
  output logic             busy
);

`ifdef FXDIV_ROUND_EN
  localparam int unsigned RND = 1;
`else
  localparam int unsigned RND = 0;
`endif
  localparam int unsigned ITER = WIDTH + FRAC;
  localparam int unsigned QW   = ITER + RND;
  localparam int unsigned CW   = $clog2(QW + 1);

  localparam logic [WIDTH-1:0] MAX_V   = {1'b0, {(WIDTH-1){1'b1}}};
  localparam logic [WIDTH-1:0] MIN_V   = {1'b1, {(WIDTH-1){1'b0}}};
  localparam logic [ITER:0]    MAG_LIM = (ITER+1)'(1) << (WIDTH-1);

  typedef enum logic [1:0] {IDLE, CALC, FIN, DONE} state_t;

  state_t           state_q;
  logic [QW-1:0]    dq_q;       // dividend bits shift out of the top, quotient bits shift in at the bottom
  logic [WIDTH:0]   rem_q;
  logic [WIDTH-1:0] den_abs_q;
  logic             sign_q;
  logic [CW-1:0]    cnt_q;
  logic             in_ready_q, out_valid_q, busy_q, dz_q, ovf_q;
  logic [WIDTH-1:0] quot_q;

  logic [WIDTH-1:0] num_abs, den_abs;
  logic [WIDTH+1:0] rem_sh;
  logic             ge;
  logic [WIDTH:0]   rem_d;
  logic [QW-1:0]    dq_d;
  logic [ITER:0]    mag;
  logic [WIDTH-1:0] quot_d;
  logic             dz_d, ovf_d;

  always_comb begin
    num_abs = num[WIDTH-1] ? -num : num;
    den_abs = den[WIDTH-1] ? -den : den;
    rem_sh  = {rem_q, dq_q[QW-1]};
    ge      = rem_sh >= {2'b00, den_abs_q};
    rem_d   = ge ? (WIDTH+1)'(rem_sh - {2'b00, den_abs_q}) : (WIDTH+1)'(rem_sh);
    dq_d    = {dq_q[QW-2:0], ge};
  end

  always_comb begin
`ifdef FXDIV_ROUND_EN
    mag = {1'b0, dq_q[QW-1:1]} + (ITER+1)'(dq_q[0]);
`else
    mag = {1'b0, dq_q};
`endif
    quot_d = '0;
    dz_d   = 1'b0;
    ovf_d  = 1'b0;
    if (den_abs_q == '0) begin
      dz_d   = 1'b1;
      quot_d = sign_q ? MIN_V : MAX_V;
    end else if (!sign_q) begin
      if (mag >= MAG_LIM) begin
        quot_d = MAX_V;
        ovf_d  = 1'b1;
      end else begin
        quot_d = mag[WIDTH-1:0];
      end
    end else begin
      // magnitude exactly 2^(WIDTH-1) negates to MIN and is not an overflow
      if (mag > MAG_LIM) begin
        quot_d = MIN_V;
        ovf_d  = 1'b1;
      end else begin
        quot_d = -mag[WIDTH-1:0];
      end
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q     <= IDLE;
      dq_q        <= '0;
      rem_q       <= '0;
      den_abs_q   <= '0;
      sign_q      <= 1'b0;
      cnt_q       <= '0;
      in_ready_q  <= 1'b1;
      out_valid_q <= 1'b0;
      busy_q      <= 1'b0;
      quot_q      <= '0;
      dz_q        <= 1'b0;
      ovf_q       <= 1'b0;
    end else begin
      case (state_q)
        IDLE: begin
          if (in_valid) begin
            dq_q       <= {num_abs, {(FRAC+RND){1'b0}}};
            den_abs_q  <= den_abs;
            sign_q     <= num[WIDTH-1] ^ den[WIDTH-1];
            rem_q      <= '0;
            cnt_q      <= CW'(QW - 1);
            dz_q       <= 1'b0;
            ovf_q      <= 1'b0;
            in_ready_q <= 1'b0;
            busy_q     <= 1'b1;
            state_q    <= (den == '0) ? FIN : CALC;
          end
        end
        CALC: begin
          rem_q <= rem_d;
          dq_q  <= dq_d;
          cnt_q <= cnt_q - 1'b1;
          if (cnt_q == '0) state_q <= FIN;
        end
        FIN: begin
          quot_q      <= quot_d;
          dz_q        <= dz_d;
          ovf_q       <= ovf_d;
          out_valid_q <= 1'b1;
          state_q     <= DONE;
        end
        DONE: begin
          if (out_ready) begin
            out_valid_q <= 1'b0;
            in_ready_q  <= 1'b1;
            busy_q      <= 1'b0;
            state_q     <= IDLE;
          end
        end
        default: state_q <= IDLE;
      endcase
    end
  end

  assign in_ready  = in_ready_q;
  assign out_valid = out_valid_q;
  assign busy      = busy_q;
  assign quot      = quot_q;
  assign div_zero  = dz_q;
  assign ovf       = ovf_q;

endmodule

// File: tb/tb_fixedpoint_div.sv
// Self-checking bench for fixedpoint_div: vector table plus random operands against a 64-bit
// reference, with backpressure and mid-calculation reset sequences.
module tb_fixedpoint_div;
  localparam int W = 32;
  localparam int F = 21;
`ifdef FXDIV_ROUND_EN
  localparam int LAT = W + F + 2;
`else
  localparam int LAT = W + F + 1;
`endif

  logic         clk = 1'b0, rst_n = 1'b0;
  logic         in_valid = 1'b0, out_ready = 1'b0;
  logic [W-1:0] num = '0, den = '0;
  logic         in_ready, out_valid, div_zero, ovf, busy;
  logic [W-1:0] quot;

  always #5 clk = ~clk;

  fixedpoint_div #(.WIDTH(W), .FRAC(F)) dut (
    .clk(clk), .rst_n(rst_n), .in_valid(in_valid), .in_ready(in_ready),
    .num(num), .den(den), .out_valid(out_valid), .out_ready(out_ready),
    .quot(quot), .div_zero(div_zero), .ovf(ovf), .busy(busy)
  );

  typedef struct {
    logic [31:0] n, d, q;
    logic        dz, ov;
  } vec_t;

  typedef struct {
    logic [31:0] q;
    logic        dz, ov;
    int          lat;
  } exp_t;

  int   n_vec = 0;
  int   n_err = 0;
  exp_t sb[$];

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    n_vec++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got %0h, expected %0h", name, act, exp);
    end
  endtask

  function automatic logic [33:0] ref_div(input logic [31:0] n, input logic [31:0] d);
    longint sn, sd, an, ad, q;
    logic [31:0] qo;
    logic neg, dz, ov;
    sn  = longint'($signed(n));
    sd  = longint'($signed(d));
    an  = (sn < 0) ? -sn : sn;
    ad  = (sd < 0) ? -sd : sd;
    neg = n[31] ^ d[31];
    dz  = 1'b0;
    ov  = 1'b0;
    if (ad == 0) begin
      dz = 1'b1;
      qo = n[31] ? 32'h8000_0000 : 32'h7FFF_FFFF;
    end else begin
`ifdef FXDIV_ROUND_EN
      q = (((an << (F + 1)) / ad) + 1) >>> 1;
`else
      q = (an << F) / ad;
`endif
      if (!neg && q > 64'sd2147483647) begin
        qo = 32'h7FFF_FFFF; ov = 1'b1;
      end else if (neg && q > 64'sd2147483648) begin
        qo = 32'h8000_0000; ov = 1'b1;
      end else begin
        qo = neg ? 32'(-q) : 32'(q);
      end
    end
    return {qo, dz, ov};
  endfunction

  // hold: cycles of backpressure in DONE, with stray in_valid pulses that must be ignored
  task automatic run_op(input string tag, input logic [31:0] n, input logic [31:0] d,
                        input logic [31:0] eq, input logic edz, input logic eov, input int hold);
    exp_t e, got;
    int t;
    t = 0;
    while (!in_ready && t < 200) begin @(negedge clk); t++; end
    if (!in_ready) begin check({tag, " in_ready timeout"}, 0, 1); return; end
    num = n; den = d; in_valid = 1'b1;
    e.q = eq; e.dz = edz; e.ov = eov;
    // den==0 goes straight to FIN: one edge after the accept edge (two counting it)
    e.lat = (d == '0) ? 1 : LAT;
    @(posedge clk);
    sb.push_back(e);
    @(negedge clk);
    in_valid = 1'b0;
    check({tag, " in_ready after accept"}, in_ready, 0);
    if (d != '0) check({tag, " busy in CALC"}, busy, 1);
    t = 0;
    while (!out_valid && t < 200) begin @(posedge clk); t++; @(negedge clk); end
    if (!out_valid) begin check({tag, " out_valid timeout"}, 0, 1); sb.delete(); return; end
    got = sb.pop_front();
    check({tag, " latency"}, t, got.lat);
    check({tag, " quot"}, quot, got.q);
    check({tag, " div_zero"}, div_zero, got.dz);
    check({tag, " ovf"}, ovf, got.ov);
    for (int i = 0; i < hold; i++) begin
      num = ~n; den = 32'h0020_0000; in_valid = (i % 2 == 0);
      @(posedge clk); @(negedge clk);
      check({tag, " hold quot"}, quot, got.q);
      check({tag, " hold flags"}, {div_zero, ovf}, {got.dz, got.ov});
      check({tag, " hold out_valid/in_ready/busy"}, {out_valid, in_ready, busy}, 3'b101);
    end
    in_valid = 1'b0;
    out_ready = 1'b1;
    @(posedge clk); @(negedge clk);
    out_ready = 1'b0;
    check({tag, " handshake out_valid/in_ready"}, {out_valid, in_ready}, 2'b01);
    if (hold > 0) begin
      repeat (3) @(negedge clk);
      check({tag, " no stray op"}, {out_valid, in_ready, busy}, 3'b010);
    end
  endtask

  vec_t tbl[14];

  initial begin
    logic [33:0] r;
    logic [31:0] rn, rd;
    int seen;

    tbl[0]  = '{32'h0030_0000, 32'h0010_0000, 32'h0060_0000, 1'b0, 1'b0};
    tbl[1]  = '{32'hFFE0_0000, 32'h0080_0000, 32'hFFF8_0000, 1'b0, 1'b0};
`ifdef FXDIV_ROUND_EN
    tbl[2]  = '{32'h0020_0000, 32'h0060_0000, 32'h000A_AAAB, 1'b0, 1'b0};
    tbl[11] = '{32'hFFE0_0000, 32'h0060_0000, 32'hFFF5_5555, 1'b0, 1'b0};
`else
    tbl[2]  = '{32'h0020_0000, 32'h0060_0000, 32'h000A_AAAA, 1'b0, 1'b0};
    tbl[11] = '{32'hFFE0_0000, 32'h0060_0000, 32'hFFF5_5556, 1'b0, 1'b0};
`endif
    tbl[3]  = '{32'h0020_0000, 32'h0000_0000, 32'h7FFF_FFFF, 1'b1, 1'b0};
    tbl[4]  = '{32'h7FFF_FFFF, 32'h0000_0001, 32'h7FFF_FFFF, 1'b0, 1'b1};
    tbl[5]  = '{32'h8000_0000, 32'hFFE0_0000, 32'h7FFF_FFFF, 1'b0, 1'b1};
    tbl[6]  = '{32'hFFE0_0000, 32'h0000_0000, 32'h8000_0000, 1'b1, 1'b0};
    tbl[7]  = '{32'h0000_0000, 32'h0000_0000, 32'h7FFF_FFFF, 1'b1, 1'b0};
    tbl[8]  = '{32'h8000_0000, 32'h0020_0000, 32'h8000_0000, 1'b0, 1'b0};
    tbl[9]  = '{32'h4000_0000, 32'hFFE0_0000, 32'hC000_0000, 1'b0, 1'b0};
    tbl[10] = '{32'h8000_0000, 32'h0010_0000, 32'h8000_0000, 1'b0, 1'b1};
    tbl[12] = '{32'h0000_0001, 32'h7FFF_FFFF, 32'h0000_0000, 1'b0, 1'b0};
    tbl[13] = '{32'h0000_0000, 32'hFFE0_0000, 32'h0000_0000, 1'b0, 1'b0};

    repeat (3) @(negedge clk);
    check("reset in_ready/out_valid/busy", {in_ready, out_valid, busy}, 3'b100);
    check("reset quot", quot, 0);
    check("reset flags", {div_zero, ovf}, 2'b00);
    rst_n = 1'b1;
    @(negedge clk);

    for (int i = 0; i < 14; i++)
      run_op($sformatf("vec%0d", i), tbl[i].n, tbl[i].d, tbl[i].q, tbl[i].dz, tbl[i].ov, 0);

    for (int i = 0; i < 10; i++) begin
      rn = $urandom >> $urandom_range(0, 24);
      rd = $urandom >> $urandom_range(4, 28);
      if ($urandom_range(0, 1) == 1) rn = -rn;
      if ($urandom_range(0, 1) == 1) rd = -rd;
      r = ref_div(rn, rd);
      run_op($sformatf("rnd%0d", i), rn, rd, r[33:2], r[1], r[0], 0);
    end

    run_op("backpressure", 32'h0030_0000, 32'h0010_0000, 32'h0060_0000, 1'b0, 1'b0, 5);

    // abort at CALC cycle 20; the previous result keeps quot non-zero until reset
    num = 32'h0020_0000; den = 32'h0060_0000; in_valid = 1'b1;
    @(posedge clk);
    sb.push_back('{32'h000A_AAAA, 1'b0, 1'b0, LAT});
    @(negedge clk);
    in_valid = 1'b0;
    repeat (20) @(negedge clk);
    check("pre-reset busy", busy, 1);
    #2 rst_n = 1'b0;
    #1;
    check("mid-reset in_ready/out_valid/busy", {in_ready, out_valid, busy}, 3'b100);
    check("mid-reset quot", quot, 0);
    check("mid-reset flags", {div_zero, ovf}, 2'b00);
    sb.delete();
    @(negedge clk);
    rst_n = 1'b1;
    seen = 0;
    repeat (70) begin
      @(negedge clk);
      if (out_valid) seen = 1;
    end
    check("aborted op emits nothing", seen, 0);
    run_op("after reset", 32'h0030_0000, 32'h0010_0000, 32'h0060_0000, 1'b0, 1'b0, 0);

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

  initial begin
    #2000000;
    $display("FAIL global timeout: simulation exceeded time limit");
    $fatal(1, "timeout");
  end
endmodule
